// File: rtl/tile_buf_seq_pkg.sv
// Shared definitions for the PREP/WAIT/COMP memory-controller FSM and its
// ping-pong buffer sequencer.
package tile_buf_seq_pkg;

  localparam int DEF_DEPTH  = 256;
  localparam int DEF_OFS_W  = 8;
  localparam int DEF_LEN_W  = 9;
  localparam int DEF_TILE_W = 8;

  // Encodings are shared bit-for-bit with the controller FSM.
  typedef enum logic [1:0] {
    PREP = 2'b00,
    COMP = 2'b01,
    WAIT = 2'b11
  } fsm_state_t;

endpackage

// File: rtl/tile_buf_seq_if.sv
// Signal bundle between the controller side (master) and the buffer
// sequencer (slave).
interface tile_buf_seq_if #(
  parameter int OFS_W  = tile_buf_seq_pkg::DEF_OFS_W,
  parameter int LEN_W  = tile_buf_seq_pkg::DEF_LEN_W,
  parameter int TILE_W = tile_buf_seq_pkg::DEF_TILE_W
);

  tile_buf_seq_pkg::fsm_state_t state;
  logic              cfg_valid;
  logic [LEN_W-1:0]  cfg_len;
  logic [TILE_W-1:0] cfg_tiles;
  logic              cfg_err;
  logic              condition0_1;
  logic              condition1_2;
  logic              condition2_1;
  logic              fill_valid;
  logic              fill_ready;
  logic              wr_en;
  logic [OFS_W:0]    wr_addr;
  logic              pe_ready;
  logic              rd_en;
  logic [OFS_W:0]    rd_addr;
  logic [TILE_W-1:0] tile_cnt;
  logic              done;

  modport master (
    output state, cfg_valid, cfg_len, cfg_tiles, fill_valid, pe_ready,
    input  cfg_err, condition0_1, condition1_2, condition2_1,
    input  fill_ready, wr_en, wr_addr, rd_en, rd_addr, tile_cnt, done
  );

  modport slave (
    input  state, cfg_valid, cfg_len, cfg_tiles, fill_valid, pe_ready,
    output cfg_err, condition0_1, condition1_2, condition2_1,
    output fill_ready, wr_en, wr_addr, rd_en, rd_addr, tile_cnt, done
  );

endinterface

// File: rtl/tile_buf_seq_pp_bank_ptr.sv
// Ping-pong bank pointer: offset counter that wraps at len-1 and flips the
// bank on wrap. Used once for the fill side and once for the drain side.
module pp_bank_ptr #(
  parameter int OFS_W = 8,
  parameter int LEN_W = 9
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             adv,
  input  logic [LEN_W-1:0] len,
  output logic [OFS_W-1:0] ofs,
  output logic             bank,
  output logic             last
);

  logic [OFS_W-1:0] ofs_r;
  logic             bank_r;

  // len is never 0 once a config is latched, so len-1 cannot alias a live offset.
  always_comb begin
    last = (LEN_W'(ofs_r) == (len - LEN_W'(1)));
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ofs_r  <= '0;
      bank_r <= 1'b0;
    end else if (adv) begin
      if (last) begin
        ofs_r  <= '0;
        bank_r <= ~bank_r;
      end else begin
        ofs_r  <= ofs_r + 1'b1;
      end
    end
  end

  assign ofs  = ofs_r;
  assign bank = bank_r;

endmodule

// File: rtl/tile_buf_seq.sv
// Condition generator and ping-pong activation-buffer sequencer for the
// PREP/WAIT/COMP memory-controller FSM (address/control only).
module tile_buf_seq
  import tile_buf_seq_pkg::*;
#(
  parameter int DEPTH  = DEF_DEPTH,
  parameter int OFS_W  = DEF_OFS_W,
  parameter int LEN_W  = DEF_LEN_W,
  parameter int TILE_W = DEF_TILE_W
) (
  input logic           clk,
  input logic           reset,
  tile_buf_seq_if.slave bus
);

  logic [LEN_W-1:0]  len_r;
  logic [TILE_W-1:0] tiles_r;
  logic [TILE_W-1:0] tile_cnt_r;
  logic              cfg_ok;
  logic              cfg_err_r;
  logic              cond01_r;
  logic              cond12_r;
  logic              cond21_r;
  logic              done_r;
  logic [1:0]        bank_full;
  logic [1:0]        bank_full_nxt;

  logic              cfg_hit;
  logic              cfg_legal;
  logic              fill_ready;
  logic              wr_en;
  logic              rd_en;
  logic              wr_done;
  logic              rd_done;

  logic [OFS_W-1:0]  wr_ofs;
  logic [OFS_W-1:0]  rd_ofs;
  logic              wr_bank;
  logic              rd_bank;
  logic              wr_last;
  logic              rd_last;

  pp_bank_ptr #(.OFS_W(OFS_W), .LEN_W(LEN_W)) u_wr_ptr (
    .clk   (clk),
    .reset (reset),
    .adv   (wr_en),
    .len   (len_r),
    .ofs   (wr_ofs),
    .bank  (wr_bank),
    .last  (wr_last)
  );

  pp_bank_ptr #(.OFS_W(OFS_W), .LEN_W(LEN_W)) u_rd_ptr (
    .clk   (clk),
    .reset (reset),
    .adv   (rd_en),
    .len   (len_r),
    .ofs   (rd_ofs),
    .bank  (rd_bank),
    .last  (rd_last)
  );

  always_comb begin
    cfg_hit   = bus.cfg_valid && (bus.state == PREP);
    cfg_legal = (bus.cfg_len != '0) && (bus.cfg_len <= LEN_W'(DEPTH)) &&
                (bus.cfg_tiles != '0);

    fill_ready = cfg_ok && !done_r && !bank_full[wr_bank];
    wr_en      = bus.fill_valid && fill_ready;
    // The condition2_1 cycle is a bubble: the FSM is still in COMP but the
    // next bank has not been handed over yet.
    rd_en      = (bus.state == COMP) && bank_full[rd_bank] && bus.pe_ready &&
                 !cond21_r;

    wr_done = wr_en && wr_last;
    rd_done = rd_en && rd_last;

    // A fill can only complete into an empty bank and a drain only out of a
    // full one, so the two updates always land on different bits.
    bank_full_nxt = bank_full;
    if (wr_done) bank_full_nxt[wr_bank] = 1'b1;
    if (rd_done) bank_full_nxt[rd_bank] = 1'b0;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      len_r      <= '0;
      tiles_r    <= '0;
      cfg_ok     <= 1'b0;
      cfg_err_r  <= 1'b0;
      cond01_r   <= 1'b0;
      cond12_r   <= 1'b0;
      cond21_r   <= 1'b0;
      bank_full  <= 2'b00;
      tile_cnt_r <= '0;
      done_r     <= 1'b0;
    end else begin
      cfg_err_r <= cfg_hit && !cfg_legal;
      if (cfg_hit && cfg_legal) begin
        len_r   <= bus.cfg_len;
        tiles_r <= bus.cfg_tiles;
        cfg_ok  <= 1'b1;
      end

      cond01_r  <= (bus.state == PREP) && cfg_ok && !cond01_r;
      cond12_r  <= (bus.state == WAIT) && bank_full[rd_bank] && !done_r &&
                   !cond12_r;
      cond21_r  <= rd_done;
      bank_full <= bank_full_nxt;

      if (rd_done) begin
        tile_cnt_r <= tile_cnt_r + 1'b1;
        if ((tile_cnt_r + 1'b1) == tiles_r) done_r <= 1'b1;
      end
    end
  end

  assign bus.cfg_err      = cfg_err_r;
  assign bus.condition0_1 = cond01_r;
  assign bus.condition1_2 = cond12_r;
  assign bus.condition2_1 = cond21_r;
  assign bus.fill_ready   = fill_ready;
  assign bus.wr_en        = wr_en;
  assign bus.wr_addr      = {wr_bank, wr_ofs};
  assign bus.rd_en        = rd_en;
  assign bus.rd_addr      = {rd_bank, rd_ofs};
  assign bus.tile_cnt     = tile_cnt_r;
  assign bus.done         = done_r;

endmodule

// File: tb/tb_tile_buf_seq.sv
// Directed bench for tile_buf_seq: a per-cycle vector table for a full
// two-tile run, then hand-written sequences for config errors, reset and len=1.
module tb_tile_buf_seq;
  import tile_buf_seq_pkg::*;

  logic clk;
  logic reset;
  int   checks;
  int   failures;

  tile_buf_seq_if bus ();

  tile_buf_seq dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    fsm_state_t  st;
    logic        cv;
    logic        fv;
    logic        pr;
    logic        err;
    logic        c01;
    logic        c12;
    logic        c21;
    logic        fr;
    logic        we;
    logic [8:0]  wa;
    logic        re;
    logic [8:0]  ra;
    logic [7:0]  tc;
    logic        dn;
  } vec_t;

  vec_t vecs [26];

  function automatic vec_t mk(fsm_state_t st, logic cv, logic fv, logic pr,
                              logic err, logic c01, logic c12, logic c21,
                              logic fr, logic we, logic [8:0] wa, logic re,
                              logic [8:0] ra, logic [7:0] tc, logic dn);
    vec_t v;
    v.st = st; v.cv = cv; v.fv = fv; v.pr = pr;
    v.err = err; v.c01 = c01; v.c12 = c12; v.c21 = c21;
    v.fr = fr; v.we = we; v.wa = wa; v.re = re; v.ra = ra;
    v.tc = tc; v.dn = dn;
    return v;
  endfunction

  task automatic chk(input string name, input int idx,
                     input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s [%0d]: got %0h expected %0h", name, idx, act, exp);
    end
  endtask

  task automatic chk_zero(input string name, input int idx);
    chk({name, ".cfg_err"},  idx, 64'(bus.cfg_err), 0);
    chk({name, ".c01"},      idx, 64'(bus.condition0_1), 0);
    chk({name, ".c12"},      idx, 64'(bus.condition1_2), 0);
    chk({name, ".c21"},      idx, 64'(bus.condition2_1), 0);
    chk({name, ".fill_rdy"}, idx, 64'(bus.fill_ready), 0);
    chk({name, ".wr_en"},    idx, 64'(bus.wr_en), 0);
    chk({name, ".wr_addr"},  idx, 64'(bus.wr_addr), 0);
    chk({name, ".rd_en"},    idx, 64'(bus.rd_en), 0);
    chk({name, ".rd_addr"},  idx, 64'(bus.rd_addr), 0);
    chk({name, ".tile_cnt"}, idx, 64'(bus.tile_cnt), 0);
    chk({name, ".done"},     idx, 64'(bus.done), 0);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.state     = PREP;
    bus.cfg_valid = 1'b0;
    bus.cfg_len   = '0;
    bus.cfg_tiles = '0;
    bus.fill_valid = 1'b0;
    bus.pe_ready  = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    idle_inputs();
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    tick();
  endtask

  task automatic cfg(input logic [8:0] len, input logic [7:0] tiles);
    bus.state     = PREP;
    bus.cfg_valid = 1'b1;
    bus.cfg_len   = len;
    bus.cfg_tiles = tiles;
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    reset    = 1'b1;
    idle_inputs();

    // Two tiles of four words: config, fill bank 0, drain bank 0 while
    // filling bank 1, drain bank 1, then done.
    //             st    cv fv pr  err c01 c12 c21 fr we wa      re ra      tc dn
    vecs[0]  = mk(PREP, 1, 0, 0,  0,  0,  0,  0,  0, 0, 9'h000, 0, 9'h000, 0, 0);
    vecs[1]  = mk(PREP, 0, 0, 0,  0,  0,  0,  0,  1, 0, 9'h000, 0, 9'h000, 0, 0);
    vecs[2]  = mk(PREP, 0, 0, 0,  0,  1,  0,  0,  1, 0, 9'h000, 0, 9'h000, 0, 0);
    vecs[3]  = mk(WAIT, 0, 1, 0,  0,  0,  0,  0,  1, 1, 9'h000, 0, 9'h000, 0, 0);
    vecs[4]  = mk(WAIT, 0, 1, 0,  0,  0,  0,  0,  1, 1, 9'h001, 0, 9'h000, 0, 0);
    vecs[5]  = mk(WAIT, 0, 1, 0,  0,  0,  0,  0,  1, 1, 9'h002, 0, 9'h000, 0, 0);
    vecs[6]  = mk(WAIT, 0, 1, 0,  0,  0,  0,  0,  1, 1, 9'h003, 0, 9'h000, 0, 0);
    vecs[7]  = mk(WAIT, 0, 0, 0,  0,  0,  0,  0,  1, 0, 9'h100, 0, 9'h000, 0, 0);
    vecs[8]  = mk(WAIT, 0, 0, 0,  0,  0,  1,  0,  1, 0, 9'h100, 0, 9'h000, 0, 0);
    vecs[9]  = mk(COMP, 0, 1, 1,  0,  0,  0,  0,  1, 1, 9'h100, 1, 9'h000, 0, 0);
    vecs[10] = mk(COMP, 0, 1, 0,  0,  0,  0,  0,  1, 1, 9'h101, 0, 9'h001, 0, 0);
    vecs[11] = mk(COMP, 0, 1, 1,  0,  0,  0,  0,  1, 1, 9'h102, 1, 9'h001, 0, 0);
    vecs[12] = mk(COMP, 0, 1, 0,  0,  0,  0,  0,  1, 1, 9'h103, 0, 9'h002, 0, 0);
    vecs[13] = mk(COMP, 0, 0, 1,  0,  0,  0,  0,  0, 0, 9'h000, 1, 9'h002, 0, 0);
    vecs[14] = mk(COMP, 0, 0, 0,  0,  0,  0,  0,  0, 0, 9'h000, 0, 9'h003, 0, 0);
    vecs[15] = mk(COMP, 0, 0, 1,  0,  0,  0,  0,  0, 0, 9'h000, 1, 9'h003, 0, 0);
    vecs[16] = mk(COMP, 0, 0, 1,  0,  0,  0,  1,  1, 0, 9'h000, 0, 9'h100, 1, 0);
    vecs[17] = mk(WAIT, 0, 0, 0,  0,  0,  0,  0,  1, 0, 9'h000, 0, 9'h100, 1, 0);
    vecs[18] = mk(WAIT, 0, 0, 0,  0,  0,  1,  0,  1, 0, 9'h000, 0, 9'h100, 1, 0);
    vecs[19] = mk(COMP, 0, 0, 1,  0,  0,  0,  0,  1, 0, 9'h000, 1, 9'h100, 1, 0);
    vecs[20] = mk(COMP, 0, 0, 1,  0,  0,  0,  0,  1, 0, 9'h000, 1, 9'h101, 1, 0);
    vecs[21] = mk(COMP, 0, 0, 1,  0,  0,  0,  0,  1, 0, 9'h000, 1, 9'h102, 1, 0);
    vecs[22] = mk(COMP, 0, 0, 1,  0,  0,  0,  0,  1, 0, 9'h000, 1, 9'h103, 1, 0);
    vecs[23] = mk(COMP, 0, 0, 1,  0,  0,  0,  1,  0, 0, 9'h000, 0, 9'h000, 2, 1);
    vecs[24] = mk(WAIT, 1, 1, 0,  0,  0,  0,  0,  0, 0, 9'h000, 0, 9'h000, 2, 1);
    vecs[25] = mk(WAIT, 0, 0, 0,  0,  0,  0,  0,  0, 0, 9'h000, 0, 9'h000, 2, 1);

    #1;
    chk_zero("por", 0);
    do_reset();
    chk_zero("after_rst", 0);

    for (int i = 0; i < 26; i++) begin
      bus.state      = vecs[i].st;
      bus.cfg_valid  = vecs[i].cv;
      bus.cfg_len    = 9'd4;
      bus.cfg_tiles  = 8'd2;
      bus.fill_valid = vecs[i].fv;
      bus.pe_ready   = vecs[i].pr;
      @(negedge clk);
      chk("cfg_err",  i, 64'(bus.cfg_err),      64'(vecs[i].err));
      chk("c01",      i, 64'(bus.condition0_1), 64'(vecs[i].c01));
      chk("c12",      i, 64'(bus.condition1_2), 64'(vecs[i].c12));
      chk("c21",      i, 64'(bus.condition2_1), 64'(vecs[i].c21));
      chk("fill_rdy", i, 64'(bus.fill_ready),   64'(vecs[i].fr));
      chk("wr_en",    i, 64'(bus.wr_en),        64'(vecs[i].we));
      chk("wr_addr",  i, 64'(bus.wr_addr),      64'(vecs[i].wa));
      chk("rd_en",    i, 64'(bus.rd_en),        64'(vecs[i].re));
      chk("rd_addr",  i, 64'(bus.rd_addr),      64'(vecs[i].ra));
      chk("tile_cnt", i, 64'(bus.tile_cnt),     64'(vecs[i].tc));
      chk("done",     i, 64'(bus.done),         64'(vecs[i].dn));
      tick();
    end

    // Illegal configs in PREP: cfg_err pulses, nothing is latched.
    do_reset();
    for (int k = 0; k < 3; k++) begin
      logic [8:0] bad_len;
      logic [7:0] bad_tiles;
      bad_len   = (k == 0) ? 9'd0 : ((k == 1) ? 9'd257 : 9'd4);
      bad_tiles = (k == 2) ? 8'd0 : 8'd2;
      cfg(bad_len, bad_tiles);
      @(negedge clk);
      chk("err_pre", k, 64'(bus.cfg_err), 0);
      tick();
      bus.cfg_valid = 1'b0;
      @(negedge clk);
      chk("err_pulse", k, 64'(bus.cfg_err), 1);
      tick();
      @(negedge clk);
      chk("err_end", k, 64'(bus.cfg_err), 0);
      chk("err_c01", k, 64'(bus.condition0_1), 0);
      chk("err_fill_rdy", k, 64'(bus.fill_ready), 0);
      tick();
    end
    // A legal config outside PREP is ignored.
    cfg(9'd4, 8'd2);
    bus.state = WAIT;
    tick();
    bus.cfg_valid = 1'b0;
    bus.state     = PREP;
    tick();
    @(negedge clk);
    chk("wait_cfg_err", 0, 64'(bus.cfg_err), 0);
    chk("wait_cfg_c01", 0, 64'(bus.condition0_1), 0);
    chk("wait_cfg_fill_rdy", 0, 64'(bus.fill_ready), 0);
    tick();

    // Asynchronous reset in the middle of draining bank 0 (rd_ofs == 2).
    do_reset();
    cfg(9'd4, 8'd2);
    tick();
    bus.cfg_valid = 1'b0;
    tick();
    tick();
    bus.state      = WAIT;
    bus.fill_valid = 1'b1;
    repeat (4) tick();
    bus.fill_valid = 1'b0;
    tick();
    tick();
    bus.state    = COMP;
    bus.pe_ready = 1'b1;
    tick();
    tick();
    #1;
    chk("mid_rd_addr", 0, 64'(bus.rd_addr), 64'h002);
    chk("mid_rd_en",   0, 64'(bus.rd_en), 1);
    #1;
    reset = 1'b1;
    #1;
    chk_zero("async_rst", 0);
    @(negedge clk);
    reset = 1'b0;
    #1;
    chk_zero("rst_release", 0);
    tick();
    cfg(9'd256, 8'd1);
    tick();
    bus.cfg_valid = 1'b0;
    @(negedge clk);
    chk("rs_cfg_err",  0, 64'(bus.cfg_err), 0);
    chk("rs_fill_rdy", 0, 64'(bus.fill_ready), 1);
    chk("rs_c01_lo",   0, 64'(bus.condition0_1), 0);
    tick();
    @(negedge clk);
    chk("rs_c01_hi", 0, 64'(bus.condition0_1), 1);
    tick();
    bus.state      = WAIT;
    bus.fill_valid = 1'b1;
    @(negedge clk);
    chk("rs_wr_en",   0, 64'(bus.wr_en), 1);
    chk("rs_wr_addr", 0, 64'(bus.wr_addr), 64'h000);
    tick();
    bus.fill_valid = 1'b0;

    // len=1, tiles=1: every accept fills a bank, every read is the last one.
    do_reset();
    cfg(9'd1, 8'd1);
    tick();
    bus.cfg_valid = 1'b0;
    tick();
    tick();
    bus.state      = WAIT;
    bus.fill_valid = 1'b1;
    @(negedge clk);
    chk("l1_wr_en",   0, 64'(bus.wr_en), 1);
    chk("l1_wr_addr", 0, 64'(bus.wr_addr), 64'h000);
    tick();
    bus.fill_valid = 1'b0;
    @(negedge clk);
    chk("l1_wr_addr_b1", 0, 64'(bus.wr_addr), 64'h100);
    chk("l1_fill_rdy",   0, 64'(bus.fill_ready), 1);
    chk("l1_c12_lo",     0, 64'(bus.condition1_2), 0);
    tick();
    @(negedge clk);
    chk("l1_c12_hi", 0, 64'(bus.condition1_2), 1);
    tick();
    bus.state    = COMP;
    bus.pe_ready = 1'b1;
    @(negedge clk);
    chk("l1_rd_en",   0, 64'(bus.rd_en), 1);
    chk("l1_rd_addr", 0, 64'(bus.rd_addr), 64'h000);
    tick();
    @(negedge clk);
    chk("l1_c21",      0, 64'(bus.condition2_1), 1);
    chk("l1_done",     0, 64'(bus.done), 1);
    chk("l1_tile_cnt", 0, 64'(bus.tile_cnt), 1);
    chk("l1_rd_en_bub",0, 64'(bus.rd_en), 0);
    chk("l1_rd_addr_b1",0, 64'(bus.rd_addr), 64'h100);
    tick();
    bus.state = WAIT;
    @(negedge clk);
    chk("l1_c21_end",  0, 64'(bus.condition2_1), 0);
    chk("l1_fill_done",0, 64'(bus.fill_ready), 0);
    tick();
    @(negedge clk);
    chk("l1_c12_done", 0, 64'(bus.condition1_2), 0);
    chk("l1_done_stk", 0, 64'(bus.done), 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
